// File: rtl/my_sync_fifo.sv
// Synchronous FIFO with occupancy counter, almost-full/almost-empty flags,
// sticky overflow/underflow errors, synchronous flush and a selectable
// read style (registered read or first-word-fall-through).
module my_sync_fifo #(
  parameter int unsigned MyDataWidth = 8,
  parameter int unsigned MyAddrWidth = 4,
  parameter int unsigned MyAfThr     = 12,
  parameter int unsigned MyAeThr     = 2,
  parameter bit          MyFwft      = 1'b0
) (
  input  logic                   myClk,
  input  logic                   myRst,
  input  logic                   myWreq,
  input  logic [MyDataWidth-1:0] myWdata,
  input  logic                   myRreq,
  output logic [MyDataWidth-1:0] myRdata,
  output logic                   myRvalid,
  input  logic                   myFlush,
  input  logic                   myClrErr,
  output logic                   myWfull,
  output logic                   myRempty,
  output logic                   myAlmostFull,
  output logic                   myAlmostEmpty,
  output logic [MyAddrWidth:0]   myCount,
  output logic                   myOverflow,
  output logic                   myUnderflow
);

  localparam int unsigned Depth = 1 << MyAddrWidth;
  localparam logic [MyAddrWidth:0]   DepthCnt = Depth[MyAddrWidth:0];
  localparam logic [MyAddrWidth:0]   AfCnt    = MyAfThr[MyAddrWidth:0];
  localparam logic [MyAddrWidth:0]   AeCnt    = MyAeThr[MyAddrWidth:0];
  localparam logic [MyAddrWidth-1:0] PtrOne   = {{(MyAddrWidth-1){1'b0}}, 1'b1};
  localparam logic [MyAddrWidth:0]   CntOne   = {{MyAddrWidth{1'b0}}, 1'b1};

  logic [MyDataWidth-1:0] mem_q [Depth];
  logic [MyAddrWidth-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [MyAddrWidth:0]   count_q, count_d;
  logic                   ovf_q, ovf_d, udf_q, udf_d;
  logic                   wfull_s, rempty_s, wr_acc_s, rd_acc_s, ovf_set_s, udf_set_s;

  // Full/empty are decoded from the counter alone, so pointer equality never matters
  assign wfull_s   = (count_q == DepthCnt);
  assign rempty_s  = (count_q == {(MyAddrWidth+1){1'b0}});
  assign wr_acc_s  = myWreq & ~wfull_s & ~myFlush;
  assign rd_acc_s  = myRreq & ~rempty_s & ~myFlush;
  assign ovf_set_s = myWreq & wfull_s & ~myFlush;
  assign udf_set_s = myRreq & rempty_s & ~myFlush;

  assign myWfull       = wfull_s;
  assign myRempty      = rempty_s;
  assign myAlmostFull  = (count_q >= AfCnt);
  assign myAlmostEmpty = (count_q <= AeCnt);
  assign myCount       = count_q;
  assign myOverflow    = ovf_q;
  assign myUnderflow   = udf_q;

  // Next-state for pointers and occupancy; flush wins over any request
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (myFlush) begin
      wptr_d  = {MyAddrWidth{1'b0}};
      rptr_d  = {MyAddrWidth{1'b0}};
      count_d = {(MyAddrWidth+1){1'b0}};
    end else begin
      if (wr_acc_s) begin
        wptr_d = wptr_q + PtrOne;
      end else begin
        wptr_d = wptr_q;
      end
      if (rd_acc_s) begin
        rptr_d = rptr_q + PtrOne;
      end else begin
        rptr_d = rptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  // Sticky error flags: a new error in the same cycle beats a clear
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (myClrErr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (udf_set_s) begin
      udf_d = 1'b1;
    end else if (myClrErr) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // Control state registers
  always_ff @(posedge myClk or posedge myRst) begin
    if (myRst) begin
      wptr_q  <= {MyAddrWidth{1'b0}};
      rptr_q  <= {MyAddrWidth{1'b0}};
      count_q <= {(MyAddrWidth+1){1'b0}};
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array; deliberately not reset, stale words stay hidden behind count
  always_ff @(posedge myClk) begin
    if (wr_acc_s) begin
      mem_q[wptr_q] <= myWdata;
    end
  end

  if (MyFwft == 1'b0) begin : g_reg_read
    logic [MyDataWidth-1:0] rdata_q, rdata_d;
    logic                   rvalid_q, rvalid_d;

    // Capture head word on an accepted pop; valid is a one-cycle pulse
    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      if (rd_acc_s) begin
        rdata_d  = mem_q[rptr_q];
        rvalid_d = 1'b1;
      end else begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
      end
    end

    // Registered read-data stage
    always_ff @(posedge myClk or posedge myRst) begin
      if (myRst) begin
        rdata_q  <= {MyDataWidth{1'b0}};
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign myRdata  = rdata_q;
    assign myRvalid = rvalid_q;
  end else begin : g_fwft_read
    // Head word falls through; masked to zero while empty so old data never leaks
    assign myRdata  = rempty_s ? {MyDataWidth{1'b0}} : mem_q[rptr_q];
    assign myRvalid = ~rempty_s;
  end

endmodule

// File: doc/my_sync_fifo.md
MY_SYNC_FIFO -- requirements
Module: my_sync_fifo

Interface
REQ-001 SHALL have parameter MyDataWidth, default 8: data word width in bits.
REQ-002 SHALL have parameter MyAddrWidth, default 4: depth = 2**MyAddrWidth entries (16).
REQ-003 SHALL have parameter MyAfThr, default 12: myAlmostFull asserts when myCount >= MyAfThr.
REQ-004 SHALL have parameter MyAeThr, default 2: myAlmostEmpty asserts when myCount <= MyAeThr.
REQ-005 SHALL have parameter MyFwft, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 SHALL have port myClk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port myRst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port myWreq, input, 1: write request.
REQ-009 SHALL have port myWdata, input, MyDataWidth: write data.
REQ-010 SHALL have port myRreq, input, 1: read request (pop).
REQ-011 SHALL have port myRdata, output, MyDataWidth: read data.
REQ-012 SHALL have port myRvalid, output, 1: myRdata valid.
REQ-013 SHALL have port myFlush, input, 1: synchronous empty command.
REQ-014 SHALL have port myClrErr, input, 1: clears sticky error flags.
REQ-015 SHALL have ports myWfull, myRempty, myAlmostFull, myAlmostEmpty, all output, 1: status flags.
REQ-016 SHALL have port myCount, output, MyAddrWidth+1: current occupancy, 0..depth.
REQ-017 SHALL have ports myOverflow, myUnderflow, output, 1: sticky error flags.

Function
REQ-018 Write accepted SHALL be myWreq & !myWfull & !myFlush; accepted data stored at write pointer, pointer +1 modulo depth.
REQ-019 Read accepted SHALL be myRreq & !myRempty & !myFlush; read pointer +1 modulo depth.
REQ-020 myCount SHALL be registered: +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-021 Simultaneous write and read accepted in same cycle SHALL leave myCount unchanged; full blocks write even with concurrent read; empty blocks read even with concurrent write.
REQ-022 myWfull = (myCount == depth), myRempty = (myCount == 0); flags SHALL derive from registered myCount, so they reflect an event on the following cycle.
REQ-023 myAlmostFull and myAlmostEmpty SHALL derive from myCount per REQ-003/REQ-004.
REQ-024 Pointers SHALL wrap from depth-1 to 0 without data corruption; full and empty SHALL be distinguished by myCount, not by pointer equality.
REQ-025 MyFwft=0: on accepted read, myRdata SHALL register the head entry and myRvalid SHALL pulse high for exactly the next cycle; otherwise myRdata holds its last value.
REQ-026 MyFwft=1: myRdata SHALL combinationally show the head entry and myRvalid SHALL equal !myRempty; an accepted read advances to the next entry.
REQ-027 myFlush SHALL, at the next edge, zero both pointers and myCount and (MyFwft=0) clear myRvalid; concurrent requests are ignored; error flags are unaffected.
REQ-028 myOverflow SHALL set on myWreq & myWfull & !myFlush; myUnderflow SHALL set on myRreq & myRempty & !myFlush.
REQ-029 myClrErr SHALL clear both error flags at the next edge; a set condition in the same cycle SHALL take priority over clear.
REQ-030 Rejected writes SHALL NOT modify memory; rejected reads SHALL NOT change myRdata or pointers.

Reset
REQ-031 myRst high SHALL immediately force: pointers 0, myCount 0, myRempty 1, myWfull 0, myAlmostEmpty 1, myAlmostFull 0, myRdata 0, myRvalid 0, myOverflow 0, myUnderflow 0.
REQ-032 Reset mid-operation SHALL discard all stored entries; memory array content is not reset and SHALL NOT be observable until rewritten.
REQ-033 Deassertion of myRst SHALL allow operation from the first subsequent rising edge.

Verification (defaults, MyFwft=0 unless stated)
REQ-034 Write 16 words 0x00..0x0F -> myWfull=1, myCount=16, myAlmostFull=1 from count 12; 17th write -> myOverflow=1, memory unchanged.
REQ-035 Read 16 from full -> myRdata 0x00..0x0F in order, myRvalid one cycle after each read, myRempty=1 at end; extra read -> myUnderflow=1.
REQ-036 Count 8, simultaneous write+read for 20 cycles -> myCount stays 8, pointers wrap, order preserved.
REQ-037 MyFwft=1: write 0xA5 into empty -> next cycle myRvalid=1, myRdata=0xA5 with no read request.
REQ-038 Count 5, assert myFlush with myWreq=1 -> myCount=0, myRempty=1, no write; then myClrErr with overflow set -> flag 0.
REQ-039 Count 10, pulse myRst mid-burst -> all outputs at REQ-031 values immediately; next read with empty -> myUnderflow=1.
